// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and timeout counter width.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_SEND   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  localparam int TMO_W = 11;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational requester picker: lowest index at or after ptr wins, wrapping at NUM_REQ-1.
// With UART_ARB_FIXED_PRIO_EN defined the pointer is ignored and index 0 always has top priority.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  logic [IDX_W-1:0] ptr_eff;
  logic [IDX_W-1:0] cand;

`ifdef UART_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign ptr_eff    = '0;
`else
  assign ptr_eff = ptr;
`endif

  // Walk from the farthest candidate back to the pointer so the nearest one is assigned last.
  always_comb begin
    idx     = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr_eff) + k) % NUM_REQ);
      if (req[cand]) begin
        idx     = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART serializer between NUM_REQ requesters with round-robin + packet lock
// (strict fixed priority when UART_ARB_FIXED_PRIO_EN is defined). Outputs are registered.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int IDX_W    = 2,
  parameter int BUSY_TMO = 2047
) (
  input  logic                 hw_clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_byte,
  output logic                 tx_send,
  input  logic                 tx_busy,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 locked,
  output logic                 tmo_err
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [7:0]           byte_q, byte_d;
  logic                 locked_q, locked_d;
  logic [TMO_W-1:0]     cnt_q, cnt_d;
  logic                 arm_q, arm_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 send_q, send_d;
  logic                 tmo_q, tmo_d;

  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [7:0]           data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[8*g +: 8];
  end

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

`ifdef UART_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Pointer only moves once a whole packet has gone out.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_DRAIN && !tx_busy && !locked_q) begin
      ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
    end
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    byte_d   = byte_q;
    locked_d = locked_q;
    cnt_d    = cnt_q;
    arm_d    = arm_q;
    ready_d  = '0;
    send_d   = 1'b0;
    tmo_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_busy) begin
          if (locked_q) begin
            if (req_valid[grant_q]) state_d = ST_ACCEPT;
          end else if (pick_any) begin
            grant_d = pick_idx;
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_ACCEPT: begin
        ready_d[grant_q] = 1'b1;
        byte_d           = data_arr[grant_q];
        locked_d         = ~req_last[grant_q];
        cnt_d            = '0;
        arm_d            = 1'b0;
        state_d          = ST_SEND;
      end
      ST_SEND: begin
        // arm_q records a low tx_busy seen in SEND, so only a fresh rising edge completes the handshake.
        if (tx_busy && arm_q) begin
          state_d = ST_DRAIN;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          send_d = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (!tx_busy) arm_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      byte_q   <= '0;
      locked_q <= 1'b0;
      cnt_q    <= '0;
      arm_q    <= 1'b0;
      ready_q  <= '0;
      send_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      byte_q   <= byte_d;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
      arm_q    <= arm_d;
      ready_q  <= ready_d;
      send_q   <= send_d;
      tmo_q    <= tmo_d;
    end
  end

  assign req_ready = ready_q;
  assign tx_byte   = byte_q;
  assign tx_send   = send_q;
  assign grant_idx = grant_q;
  assign locked    = locked_q;
  assign tmo_err   = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues and a busy-pulse serializer model feed frames to per-test checks.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int BUSY_TMO = 20;
  localparam int BUSY_LEN = 8;

  logic        hw_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_byte;
  logic        tx_send;
  logic        tx_busy = 1'b0;
  logic [1:0]  grant_idx;
  logic        locked;
  logic        tmo_err;

  int total = 0;
  int bad = 0;

  logic [8:0]  rq [NUM_REQ][$];
  logic [10:0] exp_q [$];
  logic [10:0] obs_q [$];
  bit          ser_en = 1'b1;
  int          bcnt = 0;
  int          ready_cnt = 0;
  int          frame_cnt = 0;

  uart_tx_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .IDX_W    (2),
    .BUSY_TMO (BUSY_TMO)
  ) dut (
    .hw_clk    (hw_clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_byte   (tx_byte),
    .tx_send   (tx_send),
    .tx_busy   (tx_busy),
    .grant_idx (grant_idx),
    .locked    (locked),
    .tmo_err   (tmo_err)
  );

  always #5 hw_clk = ~hw_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [10:0] mk(bit lk, int g, logic [7:0] b);
    logic [1:0] g2;
    g2 = 2'(g);
    return {lk, g2, b};
  endfunction

  task automatic set_front(int i);
    logic [8:0] t;
    if (rq[i].size() == 0) begin
      req_valid[i] = 1'b0;
    end else begin
      t = rq[i][0];
      req_data[8*i +: 8] = t[7:0];
      req_last[i] = t[8];
      req_valid[i] = 1'b1;
    end
  endtask

  task automatic load_req(int i, logic [7:0] b, bit l);
    rq[i].push_back({l, b});
    if (!req_valid[i]) set_front(i);
  endtask

  // One clock: sample just after the edge, then play requesters and serializer.
  task automatic step();
    @(posedge hw_clk);
    #1;
    if (req_ready !== 4'b0000) begin
      ready_cnt++;
      total++;
      if ($countones(req_ready) != 1) begin
        bad++;
        $display("FAIL ready_onehot: req_ready=%b want one-hot", req_ready);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) begin
          if (rq[i].size() > 0) void'(rq[i].pop_front());
          set_front(i);
        end
      end
    end
    if (ser_en) begin
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) tx_busy = 1'b0;
      end else if (tx_send === 1'b1) begin
        obs_q.push_back({locked, grant_idx, tx_byte});
        frame_cnt++;
        bcnt = BUSY_LEN;
        tx_busy = 1'b1;
      end
    end
  endtask

  task automatic clear_bench();
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    tx_busy = 1'b0;
    bcnt = 0;
    ser_en = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    exp_q.delete();
    obs_q.delete();
    ready_cnt = 0;
    frame_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_bench();
    repeat (2) @(posedge hw_clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_frames(string name, int n);
    int cyc;
    logic [10:0] o, e;
    cyc = 0;
    while (obs_q.size() < n && cyc < n * 40 + 20) begin
      step();
      cyc++;
    end
    total++;
    if (obs_q.size() < n) begin
      bad++;
      $display("FAIL %s_timeout: frames=%0d want %0d", name, obs_q.size(), n);
    end
    for (int k = 0; k < n; k++) begin
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL %s_frame%0d: got lk=%b g=%0d b=%h want lk=%b g=%0d b=%h",
                   name, k, o[10], o[9:8], o[7:0], e[10], e[9:8], e[7:0]);
        end
      end
    end
    repeat (20) step();
    total++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_leftover: extra frames=%0d unsent expected=%0d", name, obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_bench();
    req_valid = 4'b1111;
    repeat (3) @(posedge hw_clk);
    #1;
    total++; if (tx_send !== 1'b0)      begin bad++; $display("FAIL rst_tx_send: got %b want 0", tx_send); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    total++; if (tx_byte !== 8'h00)     begin bad++; $display("FAIL rst_tx_byte: got %h want 00", tx_byte); end
    total++; if (grant_idx !== 2'd0)    begin bad++; $display("FAIL rst_grant: got %0d want 0", grant_idx); end
    total++; if (locked !== 1'b0)       begin bad++; $display("FAIL rst_locked: got %b want 0", locked); end
    total++; if (tmo_err !== 1'b0)      begin bad++; $display("FAIL rst_tmo: got %b want 0", tmo_err); end
    req_valid = '0;
  endtask

  task automatic test_latency();
    do_reset();
    load_req(0, 8'h44, 1'b1);
    exp_q.push_back(mk(0, 0, 8'h44));
    step();
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL lat_ready_early: got %b want 0000", req_ready); end
    step();
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL lat_ready: got %b want 0001", req_ready); end
    total++; if (tx_send !== 1'b0)      begin bad++; $display("FAIL lat_send_early: got %b want 0", tx_send); end
    step();
    total++; if (tx_send !== 1'b1)      begin bad++; $display("FAIL lat_send: got %b want 1", tx_send); end
    total++; if (tx_byte !== 8'h44)     begin bad++; $display("FAIL lat_byte: got %h want 44", tx_byte); end
    run_frames("lat", 1);
    total++; if (ready_cnt != frame_cnt) begin bad++; $display("FAIL lat_ready_count: ready=%0d frames=%0d", ready_cnt, frame_cnt); end
  endtask

  task automatic test_round_robin();
    do_reset();
    load_req(0, 8'h41, 1'b1);
    load_req(0, 8'h41, 1'b1);
    load_req(1, 8'h42, 1'b1);
    load_req(2, 8'h43, 1'b1);
    load_req(3, 8'h44, 1'b1);
    exp_q.push_back(mk(0, 0, 8'h41));
    exp_q.push_back(mk(0, 1, 8'h42));
    exp_q.push_back(mk(0, 2, 8'h43));
    exp_q.push_back(mk(0, 3, 8'h44));
    exp_q.push_back(mk(0, 0, 8'h41));
    run_frames("rr", 5);
    total++; if (ready_cnt != frame_cnt) begin bad++; $display("FAIL rr_ready_count: ready=%0d frames=%0d", ready_cnt, frame_cnt); end
  endtask

  task automatic test_lock();
    do_reset();
    load_req(0, 8'h30, 1'b1);
    exp_q.push_back(mk(0, 0, 8'h30));
    run_frames("lock_pre", 1);
    load_req(1, "A", 1'b0);
    load_req(1, "B", 1'b0);
    load_req(1, "C", 1'b1);
    load_req(0, 8'h31, 1'b1);
    load_req(2, 8'h32, 1'b1);
    exp_q.push_back(mk(1, 1, "A"));
    exp_q.push_back(mk(1, 1, "B"));
    exp_q.push_back(mk(0, 1, "C"));
    exp_q.push_back(mk(0, 2, 8'h32));
    exp_q.push_back(mk(0, 0, 8'h31));
    run_frames("lock", 5);
    total++; if (ready_cnt != frame_cnt) begin bad++; $display("FAIL lock_ready_count: ready=%0d frames=%0d", ready_cnt, frame_cnt); end
  endtask

  task automatic test_timeout();
    bit found, early;
    do_reset();
    ser_en = 1'b0;
    load_req(0, 8'h55, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (req_ready[0]) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL tmo_ready: no req_ready seen, want 1"); end
    step();
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL tmo_locked_during: got %b want 1", locked); end
    early = 1'b0;
    repeat (BUSY_TMO - 2) begin
      step();
      if (tmo_err) early = 1'b1;
    end
    total++; if (early) begin bad++; $display("FAIL tmo_early: tmo_err=1 before %0d cycles, want 0", BUSY_TMO); end
    step();
    total++; if (tmo_err !== 1'b1) begin bad++; $display("FAIL tmo_pulse: got %b want 1", tmo_err); end
    total++; if (locked !== 1'b0)  begin bad++; $display("FAIL tmo_unlock: got %b want 0", locked); end
    total++; if (tx_send !== 1'b0) begin bad++; $display("FAIL tmo_send_drop: got %b want 0", tx_send); end
    step();
    total++; if (tmo_err !== 1'b0) begin bad++; $display("FAIL tmo_width: got %b want 0", tmo_err); end
    ser_en = 1'b1;
    load_req(3, 8'h66, 1'b1);
    exp_q.push_back(mk(0, 3, 8'h66));
    run_frames("tmo_next", 1);
  endtask

  task automatic test_reset_mid_send();
    bit found;
    do_reset();
    load_req(2, 8'h77, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (tx_send === 1'b1) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL mid_send_seen: tx_send never 1, want 1"); end
    rst_n = 1'b0;
    #1;
    total++; if (tx_send !== 1'b0)      begin bad++; $display("FAIL mid_tx_send: got %b want 0", tx_send); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_req_ready: got %b want 0000", req_ready); end
    total++; if (locked !== 1'b0)       begin bad++; $display("FAIL mid_locked: got %b want 0", locked); end
    total++; if (grant_idx !== 2'd0)    begin bad++; $display("FAIL mid_grant: got %0d want 0", grant_idx); end
    clear_bench();
    repeat (2) @(posedge hw_clk);
    #1;
    rst_n = 1'b1;
    load_req(3, 8'h13, 1'b1);
    load_req(0, 8'h10, 1'b1);
    exp_q.push_back(mk(0, 0, 8'h10));
    exp_q.push_back(mk(0, 3, 8'h13));
    run_frames("mid_after", 2);
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_req(0, 8'hA0, 1'b1);
    load_req(0, 8'hA1, 1'b1);
    load_req(3, 8'hB0, 1'b1);
    load_req(3, 8'hB1, 1'b1);
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_q.push_back(mk(0, 0, 8'hA0));
    exp_q.push_back(mk(0, 0, 8'hA1));
    exp_q.push_back(mk(0, 3, 8'hB0));
    exp_q.push_back(mk(0, 3, 8'hB1));
`else
    exp_q.push_back(mk(0, 0, 8'hA0));
    exp_q.push_back(mk(0, 3, 8'hB0));
    exp_q.push_back(mk(0, 0, 8'hA1));
    exp_q.push_back(mk(0, 3, 8'hB1));
`endif
    run_frames("b2b", 4);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_mid_send();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
